uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
Shares one UART transmitter between NUM_REQ byte sources using round-robin arbitration. Each requester presents a byte with a valid flag and receives a one-cycle ack when its byte is taken. The block drives the UART data input and the send_data strobe, and tracks the Trasmission-in-Progress flag to sequence one byte at a time. It sits between packet/parser logic and the UART instance on the ICEstick.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ID_W, 2, width of grant_id; must satisfy 2^ID_W >= NUM_REQ
TIMEOUT, 8, max cycles in WAIT_START before abort (optional feature only)

Ports:
clk  input  1  reference clock
rst  input  1  asynchronous active-high reset
req_valid  input  NUM_REQ  bit i high: requester i has a byte
req_data  input  8*NUM_REQ  byte of requester i in bits [8i+7:8i]
req_ack  output  NUM_REQ  one-cycle pulse; byte of requester i accepted
uart_data  output  8  byte to UART I_DATA
uart_send  output  1  to UART send_data; one-cycle pulse
uart_tip  input  1  UART TiP flag
grant_id  output  ID_W  index of last/current granted requester
busy  output  1  high in any state other than IDLE
tout_err  output  1  sticky timeout flag (optional feature; tied 0 otherwise)

Behaviour:
- Clock and reset: single clock domain. Reset is asynchronous and active-high. All state is cleared on assertion regardless of clk.
- Reset values: state=IDLE, req_ack=0, uart_data=0, uart_send=0, grant_id=0, busy=0, tout_err=0, RR pointer=NUM_REQ-1 (so requester 0 wins first).
- All outputs are registered.
- FSM states: IDLE, SEND, WAIT_START, WAIT_DONE.
- IDLE: if |req_valid && !uart_tip, at that edge:
  - winner w = first set bit searching from pointer+1 upward, wrapping modulo NUM_REQ.
  - uart_data <= req_data[w], grant_id <= w, pointer <= w, req_ack[w] <= 1, uart_send <= 1, next state SEND.
  - If uart_tip=1, stay in IDLE. This covers a UART still transmitting a byte issued before a reset.
- SEND (exactly 1 cycle): uart_send and req_ack are high during this cycle only; both clear at the next edge. Next state WAIT_START.
- WAIT_START: uart_send=0. Go to WAIT_DONE when uart_tip=1. The UART asserts TiP 2 cycles after uart_send.
- WAIT_DONE: stay while uart_tip=1. Go to IDLE when uart_tip=0.
- uart_data holds stable from SEND through WAIT_DONE. The UART samples it on the send_data cycle.
- Minimum spacing between grants: the SEND cycle + 2 + full frame + 1 IDLE cycle.
- Requesters: after seeing req_ack, a requester must update or drop its valid by the next cycle. A requester's valid may change freely at any time it is not granted.
- Non-winning valid requests are neither acked nor lost. They remain pending.
- Fairness: after requester i is granted, a continuously valid requester j != i is granted within NUM_REQ-1 further grants.
- Simultaneous events: a valid that rises in the same cycle IDLE evaluates takes part in arbitration. A valid that rises during SEND/WAIT waits for the next IDLE.
- Reset mid-operation: FSM returns to IDLE at once and uart_send drops. A UART frame already started runs to completion; the IDLE uart_tip guard blocks any new grant until it ends.
- busy = (state != IDLE).

Optional Feature:
Macro UART_ARB_TIMEOUT_EN.
- Defined:
  - A counter runs in WAIT_START. If uart_tip has not risen after TIMEOUT cycles, the FSM goes to IDLE and sets tout_err=1.
  - tout_err stays high until rst. The aborted byte is not re-offered; its ack has already been given.
- Not defined:
  - No counter.
  - WAIT_START waits for uart_tip indefinitely.
  - tout_err is tied to 0.

Test Plan:
1. rst release; req_valid=0001, req_data[7:0]=0x55 -> one cycle later req_ack=0001 and uart_send=1 for 1 cycle, uart_data=0x55, grant_id=0. busy stays high until the UART model drops TiP, then goes low.
2. req_valid=0101 held, bytes 0xA1/0xC3 -> grant order 0,2,0,2. uart_data sequence A1,C3,A1,C3. Exactly one ack per grant.
3. All four valid continuously -> grant_id sequence 0,1,2,3,0. No requester waits more than 3 grants.
4. Assert rst during WAIT_DONE while the UART model keeps TiP=1 for 50 more cycles, with req_valid=0010 -> no uart_send until TiP falls. Then requester 0 pointer rule applies: grant goes to 1, and 1 cycle after TiP=0 the send pulse occurs.
5. uart_tip held 1 at idle with req_valid=1000 -> no ack, no send. TiP drops -> ack[3] next edge.
6. With UART_ARB_TIMEOUT_EN and the UART model never raising TiP -> return to IDLE 8 cycles after SEND, tout_err=1. The next request is still served. Without the macro, the FSM stays in WAIT_START.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between NUM_REQ byte sources.
// Optional WAIT_START timeout with a sticky error flag when UART_ARB_TIMEOUT_EN is defined.
module uart_tx_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int TIMEOUT = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]   req_ack,
    output logic [7:0]           uart_data,
    output logic                 uart_send,
    input  logic                 uart_tip,
    output logic [ID_W-1:0]      grant_id,
    output logic                 busy,
    output logic                 tout_err
);

    typedef enum logic [1:0] {IDLE, SEND, WAIT_START, WAIT_DONE} state_e;

    state_e              state_q, state_d;
    logic [ID_W-1:0]     ptr_q, ptr_d;
    logic [ID_W-1:0]     grant_id_q, grant_id_d;
    logic [7:0]          uart_data_q, uart_data_d;
    logic [NUM_REQ-1:0]  req_ack_q, req_ack_d;
    logic                uart_send_q, uart_send_d;
    logic                busy_q, busy_d;

    logic                win_found;
    logic                hi_found;
    logic [ID_W-1:0]     hi_id, lo_id, win_id;
    logic [7:0]          win_byte;
    logic                grant;
    logic                tout_hit;

    if (NUM_REQ < 2 || NUM_REQ > 8 || (1 << ID_W) < NUM_REQ || TIMEOUT < 1) begin : g_bad_param
        $error("uart_tx_arbiter: illegal parameter combination");
    end

    // Winner is the lowest set bit above the pointer, else the lowest set bit overall (wrap).
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        win_found = 1'b0;
        hi_found  = 1'b0;
        hi_id     = '0;
        lo_id     = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                win_found = 1'b1;
                lo_id     = ID_W'(i);
                if (i > int'(ptr_q)) begin
                    hi_found = 1'b1;
                    hi_id    = ID_W'(i);
                end
            end
        end
        win_id   = hi_found ? hi_id : lo_id;
        win_byte = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_id == ID_W'(i)) win_byte = req_data[8*i +: 8];
        end
    end

    assign grant = (state_q == IDLE) && win_found && !uart_tip;

`ifdef UART_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tout_err_q, tout_err_d;

    assign tout_hit = (state_q == WAIT_START) && !uart_tip && (cnt_q == CNT_W'(TIMEOUT - 1));

    always_comb begin
        cnt_d      = '0;
        tout_err_d = tout_err_q | tout_hit;
        if (state_q == WAIT_START && !uart_tip && !tout_hit) cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q      <= '0;
            tout_err_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            tout_err_q <= tout_err_d;
        end
    end

    assign tout_err = tout_err_q;
`else
    assign tout_hit = 1'b0;
    assign tout_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:       if (grant) state_d = SEND;
            SEND:       state_d = WAIT_START;
            WAIT_START: begin
                if (uart_tip)      state_d = WAIT_DONE;
                else if (tout_hit) state_d = IDLE;
            end
            WAIT_DONE:  if (!uart_tip) state_d = IDLE;
            default:    state_d = IDLE;
        endcase
    end

    // Registered outputs: send/ack are asserted only for the grant edge, data holds until the next grant.
    always_comb begin
        ptr_d       = ptr_q;
        grant_id_d  = grant_id_q;
        uart_data_d = uart_data_q;
        uart_send_d = grant;
        busy_d      = (state_d != IDLE);
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ack_d[i] = grant && (win_id == ID_W'(i));
        end
        if (grant) begin
            ptr_d       = win_id;
            grant_id_d  = win_id;
            uart_data_d = win_byte;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q       <= ID_W'(NUM_REQ - 1);
            grant_id_q  <= '0;
            uart_data_q <= '0;
            req_ack_q   <= '0;
            uart_send_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            ptr_q       <= ptr_d;
            grant_id_q  <= grant_id_d;
            uart_data_q <= uart_data_d;
            req_ack_q   <= req_ack_d;
            uart_send_q <= uart_send_d;
            busy_q      <= busy_d;
        end
    end

    assign req_ack   = req_ack_q;
    assign uart_data = uart_data_q;
    assign uart_send = uart_send_q;
    assign grant_id  = grant_id_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: vector table, directed corner sequences and
// randomized traffic against a transaction-level reference model with a simple UART model.
module tb_uart_tx_arbiter;

    localparam int N       = 4;
    localparam int TIMEOUT = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ack;
    logic [7:0]  uart_data;
    logic        uart_send;
    logic        uart_tip;
    logic [1:0]  grant_id;
    logic        busy;
    logic        tout_err;

    uart_tx_arbiter #(.NUM_REQ(N), .ID_W(2), .TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ack   (req_ack),
        .uart_data (uart_data),
        .uart_send (uart_send),
        .uart_tip  (uart_tip),
        .grant_id  (grant_id),
        .busy      (busy),
        .tout_err  (tout_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] valid;
        logic       tip;
        logic [3:0] ack;
        logic       send;
        logic       busy;
        logic [1:0] gid;
        logic [7:0] data;
    } vec_t;

    vec_t vecs[$];

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: arbiter is free once the frame for the last grant has risen and fallen.
    bit         m_idle;
    int         m_phase;     // 0: send cycle, 1: waiting for TiP rise, 2: waiting for TiP fall
    logic [1:0] m_ptr;
    logic [1:0] m_gid;
    logic [7:0] m_data;
    bit         m_chk = 1'b1;

    bit uart_auto = 1'b0;
    int u_dly     = 0;
    int u_frame   = 0;

    int         gid_log[$];
    logic [7:0] data_log[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] pick(input logic [3:0] v, input logic [1:0] p);
        for (int k = 1; k <= N; k++) begin
            int j;
            j = (int'(p) + k) % N;
            if (v[j]) return 2'(j);
        end
        return p;
    endfunction

    function automatic logic [7:0] byte_of(input logic [31:0] d, input logic [1:0] idx);
        return d[8*idx +: 8];
    endfunction

    task automatic model_reset();
        m_idle  = 1'b1;
        m_phase = 0;
        m_ptr   = 2'(N - 1);
        m_gid   = 2'd0;
        m_data  = 8'h00;
    endtask

    task automatic step();
        bit         g;
        logic [1:0] w;
        logic [7:0] b;
        logic [3:0] ea;
        logic       tip_in;
        g = 1'b0; w = 2'd0; b = 8'h00; ea = 4'b0000;
        tip_in = uart_tip;
        if (m_idle && req_valid != 4'b0000 && !uart_tip) begin
            g  = 1'b1;
            w  = pick(req_valid, m_ptr);
            b  = byte_of(req_data, w);
            ea = 4'b0001 << w;
        end
        @(posedge clk);
        #1;
        if (g) begin
            m_idle = 1'b0; m_phase = 0; m_ptr = w; m_gid = w; m_data = b;
        end else if (!m_idle) begin
            if (m_phase == 0)      m_phase = 1;
            else if (m_phase == 1) begin if (tip_in) m_phase = 2; end
            else if (!tip_in)      m_idle = 1'b1;
        end
        if (m_chk) begin
            check("ack", req_ack, ea);
            check("send", uart_send, g);
            check("busy", busy, !m_idle);
            check("grant_id", grant_id, m_gid);
            check("uart_data", uart_data, m_data);
            check("tout_err", tout_err, 0);
        end
        if (uart_send) begin
            gid_log.push_back(int'(grant_id));
            data_log.push_back(uart_data);
        end
        if (uart_auto) begin
            if (uart_send) u_dly = 2;
            else if (u_dly > 0) begin
                u_dly--;
                if (u_dly == 0) begin
                    uart_tip = 1'b1;
                    u_frame  = $urandom_range(3, 12);
                end
            end else if (uart_tip && u_frame > 0) begin
                u_frame--;
                if (u_frame == 0) uart_tip = 1'b0;
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #2;
        check("rst_ack", req_ack, 0);
        check("rst_send", uart_send, 0);
        check("rst_busy", busy, 0);
        check("rst_grant_id", grant_id, 0);
        check("rst_uart_data", uart_data, 0);
        check("rst_tout_err", tout_err, 0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic drain();
        int c;
        req_valid = 4'b0000;
        c = 0;
        while ((busy || uart_tip) && c < 100) begin
            step();
            c++;
        end
        check("drain_idle", busy | uart_tip, 0);
    endtask

    task automatic wait_grants(input int n);
        for (int c = 0; c < 400 && gid_log.size() < n; c++) step();
        check("grant_count", gid_log.size(), n);
    endtask

    task automatic add(input logic [3:0] v, input logic t, input logic [3:0] a, input logic s,
                       input logic bz, input logic [1:0] gd, input logic [7:0] d);
        vec_t r;
        r.valid = v; r.tip = t; r.ack = a; r.send = s; r.busy = bz; r.gid = gd; r.data = d;
        vecs.push_back(r);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp2_id[4];
        int exp3_id[5];
        logic [7:0] exp2_d[4];
        logic [7:0] exp3_d[5];
        int n;

        rst = 1'b0; req_valid = 4'b0000; req_data = 32'h0; uart_tip = 1'b0;
        model_reset();
        #1;
        do_reset();

        // Single grant, busy tracking, TiP guard at idle, pointer rotation.
        add(4'b0001, 0, 4'b0001, 1, 1, 0, 8'h55);
        add(4'b0000, 0, 4'b0000, 0, 1, 0, 8'h55);
        add(4'b0000, 0, 4'b0000, 0, 1, 0, 8'h55);
        add(4'b0000, 1, 4'b0000, 0, 1, 0, 8'h55);
        add(4'b1000, 1, 4'b0000, 0, 1, 0, 8'h55);
        add(4'b1000, 0, 4'b0000, 0, 0, 0, 8'h55);
        add(4'b1000, 1, 4'b0000, 0, 0, 0, 8'h55);
        add(4'b1000, 1, 4'b0000, 0, 0, 0, 8'h55);
        add(4'b1000, 0, 4'b1000, 1, 1, 3, 8'h88);
        add(4'b0000, 0, 4'b0000, 0, 1, 3, 8'h88);
        add(4'b0000, 1, 4'b0000, 0, 1, 3, 8'h88);
        add(4'b0000, 0, 4'b0000, 0, 0, 3, 8'h88);
        add(4'b0011, 0, 4'b0001, 1, 1, 0, 8'h55);
        add(4'b0010, 0, 4'b0000, 0, 1, 0, 8'h55);
        add(4'b0010, 1, 4'b0000, 0, 1, 0, 8'h55);
        add(4'b0010, 0, 4'b0000, 0, 0, 0, 8'h55);
        add(4'b0010, 0, 4'b0010, 1, 1, 1, 8'h66);
        add(4'b0000, 0, 4'b0000, 0, 1, 1, 8'h66);
        add(4'b0000, 1, 4'b0000, 0, 1, 1, 8'h66);
        add(4'b0000, 0, 4'b0000, 0, 0, 1, 8'h66);

        req_data = {8'h88, 8'h77, 8'h66, 8'h55};
        for (int i = 0; i < vecs.size(); i++) begin
            req_valid = vecs[i].valid;
            uart_tip  = vecs[i].tip;
            step();
            check($sformatf("vec%0d_ack", i), req_ack, vecs[i].ack);
            check($sformatf("vec%0d_send", i), uart_send, vecs[i].send);
            check($sformatf("vec%0d_busy", i), busy, vecs[i].busy);
            check($sformatf("vec%0d_gid", i), grant_id, vecs[i].gid);
            check($sformatf("vec%0d_data", i), uart_data, vecs[i].data);
        end

        // Reset during WAIT_DONE while the UART frame keeps running.
        uart_tip = 1'b0;
        do_reset();
        req_valid = 4'b0001; step();
        req_valid = 4'b0010; step();
        uart_tip  = 1'b1;    step();
        step();
        do_reset();
        gid_log.delete(); data_log.delete();
        for (int i = 0; i < 50; i++) step();
        check("t4_no_send_while_tip", gid_log.size(), 0);
        uart_tip = 1'b0;
        step();
        check("t4_send_after_tip", uart_send, 1);
        check("t4_grant_id", grant_id, 1);
        req_valid = 4'b0000; step();
        uart_tip  = 1'b1;    step();
        uart_tip  = 1'b0;    step();

        // Two requesters held valid alternate.
        do_reset();
        uart_auto = 1'b1; u_dly = 0; u_frame = 0;
        req_data  = {8'h00, 8'hC3, 8'h00, 8'hA1};
        req_valid = 4'b0101;
        gid_log.delete(); data_log.delete();
        exp2_id = '{0, 2, 0, 2};
        exp2_d  = '{8'hA1, 8'hC3, 8'hA1, 8'hC3};
        wait_grants(4);
        for (int i = 0; i < 4 && i < gid_log.size(); i++) begin
            check($sformatf("t2_order%0d", i), gid_log[i], exp2_id[i]);
            check($sformatf("t2_data%0d", i), data_log[i], exp2_d[i]);
        end
        drain();

        // All four held valid: strict rotation.
        do_reset();
        req_data  = {8'h44, 8'h33, 8'h22, 8'h11};
        req_valid = 4'b1111;
        gid_log.delete(); data_log.delete();
        exp3_id = '{0, 1, 2, 3, 0};
        exp3_d  = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};
        wait_grants(5);
        for (int i = 0; i < 5 && i < gid_log.size(); i++) begin
            check($sformatf("t3_order%0d", i), gid_log[i], exp3_id[i]);
            check($sformatf("t3_data%0d", i), data_log[i], exp3_d[i]);
        end
        drain();

        // Randomized traffic against the reference model.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            req_valid = 4'($urandom_range(0, 15));
            req_data  = $urandom();
            step();
        end
        drain();

        // UART never raises TiP.
        uart_auto = 1'b0;
        uart_tip  = 1'b0;
        do_reset();
`ifdef UART_ARB_TIMEOUT_EN
        m_chk = 1'b0;
        req_data  = {8'h00, 8'h00, 8'h5A, 8'hA5};
        req_valid = 4'b0001; step();
        check("t6_first_send", uart_send, 1);
        req_valid = 4'b0000;
        n = 0;
        while (busy && n < 40) begin
            step();
            n++;
        end
        check("t6_abort_window", (n >= TIMEOUT && n <= TIMEOUT + 1), 1);
        check("t6_tout_err_set", tout_err, 1);
        req_valid = 4'b0010; step();
        check("t6_next_send", uart_send, 1);
        check("t6_next_gid", grant_id, 1);
        check("t6_next_data", uart_data, 8'h5A);
        check("t6_tout_err_sticky", tout_err, 1);
        req_valid = 4'b0000;
        do_reset();
        m_chk = 1'b1;
`else
        req_data  = {8'h00, 8'h00, 8'h5A, 8'hA5};
        req_valid = 4'b0001; step();
        req_valid = 4'b0000;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (!busy) n++;
        end
        check("t6_never_idle", n, 0);
        check("t6_still_busy", busy, 1);
        uart_tip = 1'b1; step();
        uart_tip = 1'b0; step();
        check("t6_recovered", busy, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
